vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock. It produces:
- a pixel-rate enable;
- free-running horizontal and vertical counters (porches included);
- the display-enable and sync signals consumed by the pixel-colour logic and the VGA connector.

It also emits a once-per-frame tick. Game-state logic (player positions, health bars) uses this tick to update outside the visible region.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz → 25 MHz)
- H_TOTAL, 800: pixels per line
- H_SYNC, 96: hSync low width, starting at hCount 0
- H_ACT_START, 144: first visible hCount
- H_ACT_END, 784: first non-visible hCount after the active region
- V_TOTAL, 525: lines per frame
- V_SYNC, 2: vSync low width, starting at vCount 0
- V_ACT_START, 35: first visible vCount
- V_ACT_END, 515: first non-visible vCount after the active region
- SYNC_DELAY, 1: pixel periods of sync delay (only used with VGA_SYNC_DELAY_EN), range 1–3

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, 100 MHz
- rst_l  in  1  asynchronous active-low reset
- pix_en  out  1  one-clk pulse, once every CLK_DIV clks
- hCount  out  10  horizontal position, 0..H_TOTAL-1
- vCount  out  10  vertical position, 0..V_TOTAL-1
- bright  out  1  high when hCount and vCount are both in their active ranges
- hSync  out  1  active-low horizontal sync
- vSync  out  1  active-low vertical sync
- frame_tick  out  1  one-clk pulse at the start of vertical blanking

## Operation
- Divider counter div runs 0..CLK_DIV-1 and wraps.
  - pix_en is registered: high for exactly the one clk following the edge where div reaches CLK_DIV-1.
- hCount and vCount advance only on clk edges where pix_en is high.
  - hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount wraps from V_TOTAL-1 to 0 when hCount wraps at the same time.
  - Line and frame wrap are simultaneous events at (799, 524) → (0, 0).
- bright, hSync and vSync are registered. They update on the same edge as the counters and are decoded from the new counter values, so they are always consistent with the hCount/vCount currently shown:
  - bright = (H_ACT_START ≤ hCount < H_ACT_END) && (V_ACT_START ≤ vCount < V_ACT_END)
  - hSync = !(hCount < H_SYNC)
  - vSync = !(vCount < V_SYNC)
- frame_tick is high for one clk on the edge where the counters become (0, V_ACT_END).
- Counter widths are 10 bits. Comparisons are unsigned. No intermediate value may exceed 10 bits.

## Timing
- Reset values (asserted asynchronously): div=0, pix_en=0, hCount=0, vCount=0, bright=0, hSync=0, vSync=0, frame_tick=0. Sync delay stages reset to 0.
- After rst_l deasserts:
  - first pix_en is at clk edge CLK_DIV (edges counted from 1);
  - hCount becomes 1 on that same edge.
- Reset asserted mid-frame forces all outputs to their reset values immediately. Counting restarts from (0, 0) with no partial line.
- Periods at defaults:
  - line: 800 pixels = 3200 clks;
  - frame: 525 lines = 1,680,000 clks;
  - pix_en duty: 1 in 4.
- Latency from counter value to bright/sync: 0 (same edge).

## Configuration
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - hSync and vSync pass through a SYNC_DELAY-stage shift register, advanced on pix_en.
  - This aligns sync with the rgb pipeline latency introduced by the sprite ROM read.
  - hCount, vCount, bright and frame_tick are not delayed.
- Undefined: sync outputs are undelayed and SYNC_DELAY is ignored.

## Structure
- Shared package vga_timing_pkg holds the 640x480 timing constants (H_/V_ totals, sync widths, active bounds). These are also used by sprite/bar placement logic.
- Sub-module pixel_tick_div contains the clock-enable divider: parameter CLK_DIV, ports clk, rst_l, pix_en.
- Counters, decode, frame_tick and the optional delay stay in vga_timing_gen.

## Test plan
- Reset release → pix_en first high at clk 4, then every 4 clks. hCount reads 1 after the first pulse. All outputs are 0 during reset.
- Run one full line → hSync low for exactly 96×4=384 clks from hCount 0. hCount wraps 799→0 and vCount increments once.
- Run one full frame → vSync low for exactly 2 lines (6400 clks). bright is high for 640×480 pixel periods total. frame_tick pulses exactly once, when (hCount, vCount) becomes (0, 515).
- Boundary check → bright=0 at (143, 35), (784, 35) and (200, 515); bright=1 at (144, 35) and (783, 514).
- Assert rst_l low at (400, 200) → next sampled outputs are 0 asynchronously. After release, counting resumes from (0, 0).
- With VGA_SYNC_DELAY_EN and SYNC_DELAY=1 → hSync falls one pix_en (4 clks) after hCount reaches 0 and rises at hCount 97. bright timing is unchanged.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 Hz raster timing constants shared by the timing
//                generator and the sprite / health-bar placement logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Raster counters are 10 bits wide; every bound below fits in 10 bits.
    localparam int unsigned c_CNT_W       = 10;

    // Horizontal timing, in pixel periods.
    localparam int unsigned c_H_TOTAL     = 800;
    localparam int unsigned c_H_SYNC      = 96;
    localparam int unsigned c_H_ACT_START = 144;
    localparam int unsigned c_H_ACT_END   = 784;

    // Vertical timing, in lines.
    localparam int unsigned c_V_TOTAL     = 525;
    localparam int unsigned c_V_SYNC      = 2;
    localparam int unsigned c_V_ACT_START = 35;
    localparam int unsigned c_V_ACT_END   = 515;

    // Visible area, handy for placement logic.
    localparam int unsigned c_H_VISIBLE   = c_H_ACT_END - c_H_ACT_START;
    localparam int unsigned c_V_VISIBLE   = c_V_ACT_END - c_V_ACT_START;

    typedef logic [c_CNT_W-1:0] cnt_t;

    // Half-open window test lo <= val < hi, unsigned.
    function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_timing_gen_pixel_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_tick_div
//  Description : Clock-enable divider. Produces a registered one-clk pulse
//                every CLK_DIV system clocks; the pulse is high during the
//                clk that follows the edge where the divider reaches
//                CLK_DIV-1, so logic qualified by it advances on the edge
//                where the divider wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_l,
    output logic pix_en
);

    // A divide-by-one still needs a 1-bit counter to stay legal.
    localparam int unsigned c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_next;
    logic               r_pix_en;

    // Next divider value, wrapping at CLK_DIV-1.
    always_comb begin
        w_div_next = (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
    end

    // Divider state and registered enable; enable rises as the divider reaches its last count.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_pix_en <= (w_div_next == c_DIV_LAST);
        end
    end

    assign pix_en = r_pix_en;

endmodule : pixel_tick_div
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 Hz VGA raster timing from the 100 MHz system
//                clock: pixel enable, free-running h/v counters, display
//                enable, active-low syncs and a once-per-frame tick at the
//                start of vertical blanking.
//                Optional macro VGA_SYNC_DELAY_EN delays hSync/vSync by
//                SYNC_DELAY pixel periods to line them up with the rgb
//                pipeline (sprite ROM read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = c_H_TOTAL,
    parameter int unsigned H_SYNC      = c_H_SYNC,
    parameter int unsigned H_ACT_START = c_H_ACT_START,
    parameter int unsigned H_ACT_END   = c_H_ACT_END,
    parameter int unsigned V_TOTAL     = c_V_TOTAL,
    parameter int unsigned V_SYNC      = c_V_SYNC,
    parameter int unsigned V_ACT_START = c_V_ACT_START,
    parameter int unsigned V_ACT_END   = c_V_ACT_END,
    parameter int unsigned SYNC_DELAY  = 1
) (
    input  logic         clk,
    input  logic         rst_l,
    output logic         pix_en,
    output logic [9:0]   hCount,
    output logic [9:0]   vCount,
    output logic         bright,
    output logic         hSync,
    output logic         vSync,
    output logic         frame_tick
);

    // All bounds brought into the 10-bit counter domain once.
    localparam cnt_t c_H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t c_V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t c_HS_END  = cnt_t'(H_SYNC);
    localparam cnt_t c_VS_END  = cnt_t'(V_SYNC);
    localparam cnt_t c_HA_LO   = cnt_t'(H_ACT_START);
    localparam cnt_t c_HA_HI   = cnt_t'(H_ACT_END);
    localparam cnt_t c_VA_LO   = cnt_t'(V_ACT_START);
    localparam cnt_t c_VA_HI   = cnt_t'(V_ACT_END);
    localparam cnt_t c_ONE     = cnt_t'(1);

    logic w_pix_en;
    cnt_t r_h_cnt;
    cnt_t r_v_cnt;
    cnt_t w_h_next;
    cnt_t w_v_next;
    logic w_h_wrap;
    logic w_bright_next;
    logic w_hsync_next;
    logic w_vsync_next;
    logic w_tick_next;
    logic r_bright;
    logic r_hsync_raw;
    logic r_vsync_raw;
    logic r_frame_tick;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk     (clk),
        .rst_l   (rst_l),
        .pix_en  (w_pix_en)
    );

    // Next raster position and the decode of that position, so the registered
    // bright/sync always describe the counter value shown alongside them.
    always_comb begin
        w_h_wrap      = (r_h_cnt == c_H_LAST);
        w_h_next      = w_h_wrap ? '0 : r_h_cnt + c_ONE;
        w_v_next      = r_v_cnt;
        if (w_h_wrap) begin
            w_v_next  = (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_ONE;
        end
        w_bright_next = in_window(w_h_next, c_HA_LO, c_HA_HI) &&
                        in_window(w_v_next, c_VA_LO, c_VA_HI);
        w_hsync_next  = !(w_h_next < c_HS_END);
        w_vsync_next  = !(w_v_next < c_VS_END);
        w_tick_next   = w_pix_en && (w_h_next == '0) && (w_v_next == c_VA_HI);
    end

    // Counters and decoded outputs advance together on each pixel enable.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_bright    <= 1'b0;
            r_hsync_raw <= 1'b0;
            r_vsync_raw <= 1'b0;
        end else if (w_pix_en) begin
            r_h_cnt     <= w_h_next;
            r_v_cnt     <= w_v_next;
            r_bright    <= w_bright_next;
            r_hsync_raw <= w_hsync_next;
            r_vsync_raw <= w_vsync_next;
        end
    end

    // Frame tick: single clk, on the edge entering (0, V_ACT_END).
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_tick_next;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    // Legal depth is 1..3; out-of-range settings are clamped.
    localparam int unsigned c_STAGES = (SYNC_DELAY < 1) ? 1 :
                                       ((SYNC_DELAY > 3) ? 3 : SYNC_DELAY);

    logic [c_STAGES-1:0] r_hs_dly;
    logic [c_STAGES-1:0] r_vs_dly;

    // Sync shift register, one stage per pixel period; stage 0 picks up the
    // sync value of the pixel that is just ending.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_hs_dly <= '0;
            r_vs_dly <= '0;
        end else if (w_pix_en) begin
            r_hs_dly[0] <= r_hsync_raw;
            r_vs_dly[0] <= r_vsync_raw;
            for (int i = 1; i < int'(c_STAGES); i++) begin
                r_hs_dly[i] <= r_hs_dly[i-1];
                r_vs_dly[i] <= r_vs_dly[i-1];
            end
        end
    end

    assign hSync = r_hs_dly[c_STAGES-1];
    assign vSync = r_vs_dly[c_STAGES-1];
`else
    assign hSync = r_hsync_raw;
    assign vSync = r_vsync_raw;
`endif

    assign pix_en     = w_pix_en;
    assign hCount     = r_h_cnt;
    assign vCount     = r_v_cnt;
    assign bright     = r_bright;
    assign frame_tick = r_frame_tick;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench. A full-size instance covers reset,
//                start-up, one line and a mid-line reset; a shrunken raster
//                (20x12 pixels, divide-by-2) covers frame-level behaviour and
//                the scaled analogues of the display-window corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       a_pix, a_bright, a_hs, a_vs, a_ft;
    logic [9:0] a_h, a_v;
    logic       s_pix, s_bright, s_hs, s_vs, s_ft;
    logic [9:0] s_h, s_v;

    int checks = 0;
    int errors = 0;

    vga_timing_gen u_dut (
        .clk(clk), .rst_l(rst_a), .pix_en(a_pix), .hCount(a_h), .vCount(a_v),
        .bright(a_bright), .hSync(a_hs), .vSync(a_vs), .frame_tick(a_ft)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
        .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(10), .SYNC_DELAY(1)
    ) u_small (
        .clk(clk), .rst_l(rst_b), .pix_en(s_pix), .hCount(s_h), .vCount(s_v),
        .bright(s_bright), .hSync(s_hs), .vSync(s_vs), .frame_tick(s_ft)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=reached", name);
    endtask

    task automatic wait_def(input int h, input int v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (a_h == 10'(h) && a_v == 10'(v)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_small(input int h, input int v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (s_h == 10'(h) && s_v == 10'(v)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int   h;
        int   v;
        logic b;
        logic hs;
        logic vs;
        logic ft;
    } vec_t;

    vec_t vecs [14];

    initial begin
        bit ok;
        int n, p, b, t, vl, th, tv;
        bit left;

        // Shrunken raster: active h 5..16, v 3..9; hs low h<3; vs low v<2.
        vecs[0]  = '{0,  0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2,  1,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3,  1,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0,  2,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4,  3,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{5,  3,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{16, 3,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{17, 3,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{16, 9,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{19, 9,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{0,  10, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{8,  10, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{19, 11, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{0,  0,  1'b0, 1'b0, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix_en", a_pix, 0);
        check("rst_hcount", a_h, 0);
        check("rst_vcount", a_v, 0);
        check("rst_bright", a_bright, 0);
        check("rst_hsync", a_hs, 0);
        check("rst_vsync", a_vs, 0);
        check("rst_frame_tick", a_ft, 0);
        check("rst_small_all", {s_pix, s_h, s_v, s_bright, s_hs, s_vs, s_ft}, 0);

        // ---------------- start-up: first pix_en ahead of edge 4 ----------------
        rst_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("startup_pix_en_e%0d", k), a_pix, ((k % 4) == 3) ? 1 : 0);
            if (k == 3) check("startup_h_before", a_h, 0);
            if (k == 4) check("startup_h_first", a_h, 1);
            if (k == 8) check("startup_h_second", a_h, 2);
        end

        // ---------------- one line ----------------
        wait_def(799, 0, 4000, ok);
        if (!ok) timeout("reach_799_0");
        n = 0;
        while (a_h != 10'd0 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("line_wrap_h", a_h, 0);
        check("line_wrap_v", a_v, 1);
`ifdef VGA_SYNC_DELAY_EN
        check("dly_hsync_at_h0", a_hs, 1);
        repeat (4) @(negedge clk);
        check("dly_hsync_fall", a_hs, 0);
        check("dly_hsync_fall_h", a_h, 1);
`else
        check("hsync_fall_at_h0", a_hs, 0);
`endif
        n = 0;
        while (a_hs == 1'b0 && n < 4000) begin
            n++;
            @(negedge clk);
        end
        check("hsync_low_clks", n, 384);
`ifdef VGA_SYNC_DELAY_EN
        check("hsync_rise_h", a_h, 97);
`else
        check("hsync_rise_h", a_h, 96);
`endif
        check("bright_line1", a_bright, 0);

        // Line period and pix_en duty over a whole line.
        wait_def(0, 2, 8000, ok);
        if (!ok) timeout("reach_0_2");
        n = 0;
        p = 0;
        while (!(a_h == 10'd0 && a_v == 10'd3) && n < 5000) begin
            p += int'(a_pix);
            @(negedge clk);
            n++;
        end
        check("line_period_clks", n, 3200);
        check("line_pix_en_count", p, 800);

        // ---------------- mid-line asynchronous reset ----------------
        wait_def(400, 3, 4000, ok);
        if (!ok) timeout("reach_400_3");
        #2 rst_a = 1'b0;
        #1;
        check("async_rst_all_zero", {a_pix, a_h, a_v, a_bright, a_hs, a_vs, a_ft}, 0);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (4) @(negedge clk);
        check("restart_h", a_h, 1);
        check("restart_v", a_v, 0);

        // ---------------- table vectors, shrunken raster ----------------
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 14; i++) begin
            wait_small(vecs[i].h, vecs[i].v, 600, ok);
            if (!ok) begin
                timeout($sformatf("vec%0d_reach", i));
            end else begin
                check($sformatf("vec%0d_bright", i), s_bright, vecs[i].b);
                check($sformatf("vec%0d_frame_tick", i), s_ft, vecs[i].ft);
`ifndef VGA_SYNC_DELAY_EN
                check($sformatf("vec%0d_hsync", i), s_hs, vecs[i].hs);
                check($sformatf("vec%0d_vsync", i), s_vs, vecs[i].vs);
`endif
            end
        end

        // ---------------- one full shrunken frame from (0,0) ----------------
        n = 0; b = 0; t = 0; vl = 0; th = -1; tv = -1; left = 1'b0;
        while (!(left && s_h == 10'd0 && s_v == 10'd0) && n < 2000) begin
            b  += int'(s_bright);
            vl += int'(!s_vs);
            if (s_ft) begin
                t++;
                th = int'(s_h);
                tv = int'(s_v);
            end
            @(negedge clk);
            n++;
            if (!(s_h == 10'd0 && s_v == 10'd0)) left = 1'b1;
        end
        check("frame_period_clks", n, 480);
        check("frame_bright_clks", b, 168);
        check("frame_vsync_low_clks", vl, 80);
        check("frame_tick_count", t, 1);
        check("frame_tick_h", th, 0);
        check("frame_tick_v", tv, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
